// File: rtl/wb_grf.sv
// wb_grf: MIPS write-back stage with 32x32 register file, write-through read bypass and retire counter.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   instr_W, PC_W       W-stage instruction (0 = bubble) and its PC
//   readData_W          raw data-memory word for a load in W
//   aluResult_W         ALU result; [1:0] is the byte offset for loads
//   cp0Out_W            CP0 read value for mfc0
//   regWrite_W, A3_W    write enable and destination register
//   write2reg_W         write-back source select (0 alu, 1 load, 2 PC+8, 3 cp0)
//   lsOp_W              load type (0 lw, 1 lb, 2 lbu, 3 lh, 4 lhu)
//   A1_D, A2_D          D-stage read addresses
//   RD1_D, RD2_D        D-stage read data (combinational, bypassed from W)
//   wbData_W, wbEn_W    selected write-back value and effective write enable
//   retired             count of non-bubble instructions that left W
module wb_grf (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_W,
    input  logic [31:0] PC_W,
    input  logic [31:0] readData_W,
    input  logic [31:0] aluResult_W,
    input  logic [31:0] cp0Out_W,
    input  logic        regWrite_W,
    input  logic [4:0]  A3_W,
    input  logic [2:0]  write2reg_W,
    input  logic [3:0]  lsOp_W,
    input  logic [4:0]  A1_D,
    input  logic [4:0]  A2_D,
    output logic [31:0] RD1_D,
    output logic [31:0] RD2_D,
    output logic [31:0] wbData_W,
    output logic        wbEn_W,
    output logic [31:0] retired
);
    logic [31:0] regs_q [1:31];
    logic [31:0] retired_q, retired_d;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [1:0]  off;

    assign off = aluResult_W[1:0];

    // Little-endian lane select: byte at off, half at off[1].
    always_comb begin
        ld_byte = off == 2'd0 ? readData_W[7:0] :
                  off == 2'd1 ? readData_W[15:8] :
                  off == 2'd2 ? readData_W[23:16] : readData_W[31:24];
        ld_half = off[1] ? readData_W[31:16] : readData_W[15:0];
        ld_data = lsOp_W == 4'd1 ? {{24{ld_byte[7]}}, ld_byte} :
                  lsOp_W == 4'd2 ? {24'd0, ld_byte} :
                  lsOp_W == 4'd3 ? {{16{ld_half[15]}}, ld_half} :
                  lsOp_W == 4'd4 ? {16'd0, ld_half} : readData_W;
    end

    always_comb begin
        wbData_W = write2reg_W == 3'd1 ? ld_data :
                   write2reg_W == 3'd2 ? PC_W + 32'd8 :
                   write2reg_W == 3'd3 ? cp0Out_W : aluResult_W;
        wbEn_W   = regWrite_W && A3_W != 5'd0;
    end

    // Each port resolves independently: $0, then same-cycle W write, then storage.
    always_comb begin
        RD1_D = A1_D == 5'd0 ? 32'd0 :
                (wbEn_W && A1_D == A3_W) ? wbData_W : regs_q[A1_D];
        RD2_D = A2_D == 5'd0 ? 32'd0 :
                (wbEn_W && A2_D == A3_W) ? wbData_W : regs_q[A2_D];
    end

    assign retired_d = instr_W != 32'd0 ? retired_q + 32'd1 : retired_q;
    assign retired   = retired_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) regs_q[i] <= 32'd0;
            retired_q <= 32'd0;
        end else begin
            if (wbEn_W) regs_q[A3_W] <= wbData_W;
            retired_q <= retired_d;
        end
    end
endmodule

// File: tb/tb_wb_grf.sv
// tb_wb_grf: directed self-checking bench for wb_grf.
module tb_wb_grf;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_W, PC_W, readData_W, aluResult_W, cp0Out_W;
    logic        regWrite_W;
    logic [4:0]  A3_W, A1_D, A2_D;
    logic [2:0]  write2reg_W;
    logic [3:0]  lsOp_W;
    logic [31:0] RD1_D, RD2_D, wbData_W, retired;
    logic        wbEn_W;
    int          n_checks = 0;
    int          n_fail = 0;

    wb_grf dut (
        .clk(clk), .reset(reset), .instr_W(instr_W), .PC_W(PC_W),
        .readData_W(readData_W), .aluResult_W(aluResult_W), .cp0Out_W(cp0Out_W),
        .regWrite_W(regWrite_W), .A3_W(A3_W), .write2reg_W(write2reg_W),
        .lsOp_W(lsOp_W), .A1_D(A1_D), .A2_D(A2_D), .RD1_D(RD1_D), .RD2_D(RD2_D),
        .wbData_W(wbData_W), .wbEn_W(wbEn_W), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        reset = 0; instr_W = 0; PC_W = 0; readData_W = 0; aluResult_W = 0;
        cp0Out_W = 0; regWrite_W = 0; A3_W = 0; write2reg_W = 0; lsOp_W = 0;
        A1_D = 0; A2_D = 0;
    endtask

    task automatic test_reset();
        idle();
        @(negedge clk);
        reset = 1; instr_W = 32'h1; regWrite_W = 1; A3_W = 5; aluResult_W = 32'h12345678;
        A1_D = 5; A2_D = 31;
        #1;
        if (wbData_W !== 32'h12345678) begin $display("FAIL reset_wbdata got %h exp %h", wbData_W, 32'h12345678); n_fail++; end
        n_checks++;
        if (wbEn_W !== 1'b1) begin $display("FAIL reset_wben got %b exp 1", wbEn_W); n_fail++; end
        n_checks++;
        tick();
        reset = 0; instr_W = 0; regWrite_W = 0;
        #1;
        if (RD1_D !== 32'h0) begin $display("FAIL reset_rd1 got %h exp 0", RD1_D); n_fail++; end
        n_checks++;
        if (RD2_D !== 32'h0) begin $display("FAIL reset_rd2 got %h exp 0", RD2_D); n_fail++; end
        n_checks++;
        if (retired !== 32'h0) begin $display("FAIL reset_retired got %h exp 0", retired); n_fail++; end
        n_checks++;
    endtask

    task automatic test_alu_bypass();
        idle();
        write2reg_W = 0; A3_W = 8; aluResult_W = 32'hDEADBEEF; regWrite_W = 1; A1_D = 8;
        #1;
        if (RD1_D !== 32'hDEADBEEF) begin $display("FAIL alu_bypass got %h exp deadbeef", RD1_D); n_fail++; end
        n_checks++;
        tick();
        regWrite_W = 0; aluResult_W = 32'h0;
        #1;
        if (RD1_D !== 32'hDEADBEEF) begin $display("FAIL alu_stored got %h exp deadbeef", RD1_D); n_fail++; end
        n_checks++;
    endtask

    task automatic test_load();
        logic [3:0]  ops  [8] = '{4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd1, 4'd0, 4'd7};
        logic [1:0]  offs [8] = '{2'd0, 2'd2, 2'd3, 2'd2, 2'd0, 2'd3, 2'd1, 2'd2};
        logic [31:0] exps [8] = '{32'h00000001, 32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF,
                                  32'h00007F01, 32'hFFFFFF80, 32'h80FF7F01, 32'h80FF7F01};
        idle();
        readData_W = 32'h80FF7F01; write2reg_W = 1;
        for (int i = 0; i < 8; i++) begin
            lsOp_W = ops[i]; aluResult_W = {30'h0, offs[i]};
            #1;
            if (wbData_W !== exps[i]) begin
                $display("FAIL load_%0d lsOp=%0d off=%0d got %h exp %h", i, ops[i], offs[i], wbData_W, exps[i]);
                n_fail++;
            end
            n_checks++;
        end
        // load result actually lands in the register file
        regWrite_W = 1; A3_W = 12; lsOp_W = 3; aluResult_W = 32'h2;
        tick();
        idle(); A1_D = 12;
        #1;
        if (RD1_D !== 32'hFFFF80FF) begin $display("FAIL load_store got %h exp ffff80ff", RD1_D); n_fail++; end
        n_checks++;
    endtask

    task automatic test_zero_pc_cp0();
        idle();
        A3_W = 0; regWrite_W = 1; aluResult_W = 5; A1_D = 0;
        #1;
        if (wbEn_W !== 1'b0) begin $display("FAIL zero_wben got %b exp 0", wbEn_W); n_fail++; end
        n_checks++;
        if (RD1_D !== 32'h0) begin $display("FAIL zero_rd1 got %h exp 0", RD1_D); n_fail++; end
        n_checks++;
        tick();
        write2reg_W = 2; PC_W = 32'h00003000; A3_W = 31;
        tick();
        write2reg_W = 3; cp0Out_W = 32'h0000ABCD; A3_W = 2;
        tick();
        write2reg_W = 2; PC_W = 32'hFFFFFFFC; regWrite_W = 0;
        #1;
        if (wbData_W !== 32'h00000004) begin $display("FAIL pc_wrap got %h exp 4", wbData_W); n_fail++; end
        n_checks++;
        idle(); A1_D = 31; A2_D = 2;
        #1;
        if (RD1_D !== 32'h00003008) begin $display("FAIL pc8 got %h exp 3008", RD1_D); n_fail++; end
        n_checks++;
        if (RD2_D !== 32'h0000ABCD) begin $display("FAIL cp0 got %h exp abcd", RD2_D); n_fail++; end
        n_checks++;
        A1_D = 0;
        #1;
        if (RD1_D !== 32'h0) begin $display("FAIL zero_after got %h exp 0", RD1_D); n_fail++; end
        n_checks++;
    endtask

    task automatic test_dual_bypass();
        idle();
        regWrite_W = 1; A3_W = 9; aluResult_W = 32'h11;
        tick();
        aluResult_W = 32'h55; A1_D = 9; A2_D = 9;
        #1;
        if (RD1_D !== 32'h55) begin $display("FAIL dual_rd1 got %h exp 55", RD1_D); n_fail++; end
        n_checks++;
        if (RD2_D !== 32'h55) begin $display("FAIL dual_rd2 got %h exp 55", RD2_D); n_fail++; end
        n_checks++;
        regWrite_W = 0;
        #1;
        if (RD1_D !== 32'h11 || RD2_D !== 32'h11) begin
            $display("FAIL dual_nobypass got %h/%h exp 11/11", RD1_D, RD2_D); n_fail++;
        end
        n_checks++;
        regWrite_W = 1; A2_D = 8;
        #1;
        if (RD1_D !== 32'h55 || RD2_D !== 32'hDEADBEEF) begin
            $display("FAIL split_ports got %h/%h exp 55/deadbeef", RD1_D, RD2_D); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_mid_reset();
        idle();
        regWrite_W = 1; A3_W = 3; aluResult_W = 32'h33;
        tick();
        reset = 1; A3_W = 4; aluResult_W = 32'h44;
        tick();
        reset = 0; A3_W = 6; aluResult_W = 32'h66;
        tick();
        idle(); A1_D = 3; A2_D = 4;
        #1;
        if (RD1_D !== 32'h0 || RD2_D !== 32'h0) begin
            $display("FAIL mid_reset_clear got %h/%h exp 0/0", RD1_D, RD2_D); n_fail++;
        end
        n_checks++;
        A1_D = 6; A2_D = 9;
        #1;
        if (RD1_D !== 32'h66) begin $display("FAIL mid_reset_next got %h exp 66", RD1_D); n_fail++; end
        n_checks++;
        if (RD2_D !== 32'h0) begin $display("FAIL mid_reset_other got %h exp 0", RD2_D); n_fail++; end
        n_checks++;
    endtask

    task automatic test_retire();
        idle();
        reset = 1;
        tick();
        reset = 0;
        instr_W = 32'h00000020;
        repeat (3) tick();
        instr_W = 0;
        repeat (2) tick();
        instr_W = 32'h8C010000;
        tick();
        instr_W = 0;
        #1;
        if (retired !== 32'd4) begin $display("FAIL retire_count got %0d exp 4", retired); n_fail++; end
        n_checks++;
        force dut.retired_q = 32'hFFFFFFFF;
        #1;
        release dut.retired_q;
        #1;
        if (retired !== 32'hFFFFFFFF) begin $display("FAIL retire_preload got %h exp ffffffff", retired); n_fail++; end
        n_checks++;
        instr_W = 32'h1;
        tick();
        instr_W = 0;
        #1;
        if (retired !== 32'h0) begin $display("FAIL retire_wrap got %h exp 0", retired); n_fail++; end
        n_checks++;
    endtask

    initial begin
        idle();
        test_reset();
        test_alu_bypass();
        test_load();
        test_zero_pc_cp0();
        test_dual_bypass();
        test_mid_reset();
        test_retire();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_grf.md
# wb_grf

Write-back stage and general register file for the pipelined MIPS core. It consumes the W-stage bundle produced by the M/W pipeline register and selects the write-back value. Load data is extracted and extended, then written into a 32×32 register file. The block also serves the two D-stage read ports with same-cycle write-through bypass and keeps a retired-instruction counter for debug.

## Interface
- No parameters.
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- instr_W  in  32  W-stage instruction; 0 means bubble/no instruction
- PC_W  in  32  W-stage PC
- readData_W  in  32  raw DM word read for the W instruction
- aluResult_W  in  32  ALU result; [1:0] is byte offset for loads
- cp0Out_W  in  32  CP0 read value (mfc0)
- regWrite_W  in  1  write enable
- A3_W  in  5  destination register
- write2reg_W  in  3  write-back source select
- lsOp_W  in  4  load type
- A1_D  in  5  read-port-1 address
- A2_D  in  5  read-port-2 address
- RD1_D  out  32  read-port-1 data
- RD2_D  out  32  read-port-2 data
- wbData_W  out  32  selected write-back value (for forwarding from W)
- wbEn_W  out  1  regWrite_W & (A3_W != 0)
- retired  out  32  count of non-bubble instructions that completed W

## Operation
- Load extraction from readData_W, little-endian, off = aluResult_W[1:0]:
  - lsOp 0: lw, full word.
  - lsOp 1: lb, sign-extended byte at off.
  - lsOp 2: lbu, zero-extended byte at off.
  - lsOp 3: lh, sign-extended half at off[1].
  - lsOp 4: lhu, zero-extended half at off[1].
  - Any other lsOp: full word.
- write2reg_W select:
  - 0: aluResult_W
  - 1: extracted load data
  - 2: PC_W + 8, 32-bit wrap
  - 3: cp0Out_W
  - 4–7: aluResult_W
- Register file:
  - 31 storage registers, $1–$31.
  - $0 reads 0 always; writes to $0 are discarded.
- Write: at posedge with !reset and wbEn_W, reg[A3_W] <= wbData_W.
- Read: combinational.
  - RDn_D = 0 if An_D == 0.
  - Else RDn_D = wbData_W if wbEn_W and An_D == A3_W (write-through).
  - Else RDn_D = reg[An_D].
- Both read ports may hit the same register or the W bypass simultaneously; each resolves independently.
- Retire counter:
  - At posedge with !reset and instr_W != 0, retired <= retired + 1.
  - Wraps 0xFFFFFFFF -> 0.
  - Counts regardless of regWrite_W.
- wbData_W and wbEn_W are purely combinational from the W inputs; no internal state.

## Timing
- Reset, when sampled high at posedge:
  - All 31 registers <= 0 and retired <= 0.
  - A write or retire presented in the same cycle is dropped.
- After reset, RD1_D, RD2_D and retired read 0 until first write or retire. wbData_W and wbEn_W follow the inputs, including during reset.
- Write latency:
  - Visible in storage 1 cycle after the write edge.
  - Visible on RDn_D in the same cycle via bypass.
- Reset asserted mid-stream clears state at that edge only; the next cycle's W bundle writes normally.
- Read path: no clocked element between An_D and RDn_D.

## Test plan
- Reset, then A1_D=5, A2_D=31 -> RD1_D=RD2_D=0 and retired=0. Write $5=0x12345678 during a reset cycle -> $5 still 0 afterwards.
- write2reg=0, A3=8, aluResult=0xDEADBEEF, regWrite=1, A1_D=8 in same cycle -> RD1_D=0xDEADBEEF before the edge. After the edge with regWrite=0, RD1_D is still 0xDEADBEEF.
- readData=0x80FF7F01, write2reg=1, lsOp=1:
  - off 0 -> 0x00000001.
  - off 2 -> 0xFFFFFFFF.
  - lsOp=2, off 3 -> 0x00000080.
  - lsOp=3, off 2 -> 0xFFFF80FF.
  - lsOp=4, off 0 -> 0x00007F01.
- A3=0, regWrite=1, aluResult=5 -> wbEn_W=0 and A1_D=0 reads 0. write2reg=2, PC=0x00003000, A3=31 -> $31=0x00003008. write2reg=3, cp0Out=0xABCD, A3=2 -> $2=0xABCD.
- A1_D=A2_D=A3_W=9 with wbEn_W=1 -> both ports return wbData_W.
- Retire counter:
  - 3 cycles instr_W nonzero, 2 bubbles, 1 nonzero -> retired=4.
  - Force the counter to 0xFFFFFFFF, then one retire -> retired=0.
